// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux.
// Grants are registered, one-hot or zero, and ownership is bounded by HOLD_MAX while others wait.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       valid
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // All registered arbiter state lives in one struct so checkers can bind to it.
  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       last_ptr;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic             valid;
  } arb_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_t             cur;
  state_t           state_d;
  logic [CNT_W-1:0] hold_d;
  logic [1:0]       ptr_d;
  logic [1:0]       owner_d;
  logic [3:0]       grant_d;
  logic [1:0]       sel_d;
  logic             valid_d;
  logic [3:0]       others;
  logic [2:0]       pick_all;
  logic [2:0]       pick_oth;

  // Returns {found, index}: first set bit of r searching ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] cand;
    res = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr + i[1:0];
      if (!res[2] && r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  // In GRANT the owner is sel, and last_ptr equals it, so both searches start at owner+1.
  assign others   = req & ~(4'b0001 << cur.sel);
  assign pick_all = rr_pick(req, cur.last_ptr);
  assign pick_oth = rr_pick(others, cur.sel);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= '{state: IDLE, hold_cnt: '0, last_ptr: 2'b11,
               grant: 4'b0000, sel: 2'b00, valid: 1'b0};
    end else begin
      cur <= '{state: state_d, hold_cnt: hold_d, last_ptr: ptr_d,
               grant: grant_d, sel: sel_d, valid: valid_d};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = cur.state;
    hold_d  = cur.hold_cnt;
    ptr_d   = cur.last_ptr;
    owner_d = cur.sel;
    case (cur.state)
      IDLE: begin
        if (pick_all[2]) begin
          state_d = GRANT;
          owner_d = pick_all[1:0];
          ptr_d   = pick_all[1:0];
          hold_d  = CNT_ONE;
        end
      end
      GRANT: begin
        if (!req[cur.sel]) begin
          if (pick_oth[2]) begin
            owner_d = pick_oth[1:0];
            ptr_d   = pick_oth[1:0];
            hold_d  = CNT_ONE;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (cur.hold_cnt < HOLD_LIM) begin
          hold_d = cur.hold_cnt + CNT_ONE;
        end else if (pick_oth[2]) begin
          // Hold budget spent with others waiting: forced rotation.
          owner_d = pick_oth[1:0];
          ptr_d   = pick_oth[1:0];
          hold_d  = CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; sel keeps its last value while idle so the mux output stays stable.
  always_comb begin
    grant_d = 4'b0000;
    sel_d   = cur.sel;
    valid_d = 1'b0;
    if (state_d == GRANT) begin
      grant_d = 4'b0001 << owner_d;
      sel_d   = owner_d;
      valid_d = 1'b1;
    end
  end

  assign grant = cur.grant;
  assign sel   = cur.sel;
  assign valid = cur.valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (HOLD_MAX=8 and HOLD_MAX=1) against a reference model,
// with expected {valid, sel, grant} queued at drive time and compared one clock later.
module tb_mux4_rr_arbiter;
  localparam int W = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic [1:0] sel_a, sel_b;
  logic       valid_a, valid_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  int m_owner[2];
  int m_cnt[2];
  int m_ptr[2];
  int m_sel[2];
  int hold_max[2] = '{8, 1};

  // Clock / reset
  always #5 clk = ~clk;

  mux4_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .grant(grant_a), .sel(sel_a), .valid(valid_a)
  );

  mux4_rr_arbiter #(.HOLD_MAX(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .grant(grant_b), .sel(sel_b), .valid(valid_b)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got {valid,sel,grant}=%b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model
  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_cnt[k]   = 0;
      m_ptr[k]   = 3;
      m_sel[k]   = 0;
    end
  endfunction

  function automatic int rr_next(input logic [3:0] r, input int from);
    for (int i = 1; i <= 4; i++) begin
      int idx;
      idx = (from + i) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] model_step(input int k, input logic [3:0] r);
    logic [3:0] oth;
    int w;
    logic [3:0] g;
    if (m_owner[k] < 0) begin
      w = rr_next(r, m_ptr[k]);
      if (w >= 0) begin
        m_owner[k] = w;
        m_cnt[k]   = 1;
        m_ptr[k]   = w;
      end
    end else begin
      oth = r;
      oth[m_owner[k]] = 1'b0;
      w = rr_next(oth, m_owner[k]);
      if (!r[m_owner[k]]) begin
        m_owner[k] = w;
        if (w >= 0) begin
          m_cnt[k] = 1;
          m_ptr[k] = w;
        end
      end else if (m_cnt[k] < hold_max[k]) begin
        m_cnt[k]++;
      end else if (w >= 0) begin
        m_owner[k] = w;
        m_cnt[k]   = 1;
        m_ptr[k]   = w;
      end
    end
    g = 4'b0000;
    if (m_owner[k] >= 0) begin
      g[m_owner[k]] = 1'b1;
      m_sel[k] = m_owner[k];
    end
    return {m_owner[k] >= 0, 2'(m_sel[k]), g};
  endfunction

  // Driver: called at a falling edge, returns at the next falling edge.
  task automatic cycle(input string tag, input logic [3:0] ra, input logic [3:0] rb);
    req_a = ra;
    req_b = rb;
    exp_q_a.push_back(model_step(0, ra));
    exp_q_b.push_back(model_step(1, rb));
    @(posedge clk);
    #1;
    check({tag, "_a"}, {valid_a, sel_a, grant_a}, exp_q_a.pop_front());
    check({tag, "_b"}, {valid_b, sel_b, grant_b}, exp_q_b.pop_front());
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra, rb;
    rst   = 1'b1;
    req_a = 4'b1111;
    req_b = 4'b0101;
    model_reset();
    #1;
    check("reset_async_a", {valid_a, sel_a, grant_a}, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold_a", {valid_a, sel_a, grant_a}, '0);
      check("reset_hold_b", {valid_b, sel_b, grant_b}, '0);
    end
    @(negedge clk);
    rst = 1'b0;

    cycle("rst_release", 4'b1111, 4'b0101);
    check("first_grant_a", {valid_a, sel_a, grant_a}, 7'b1_00_0001);
    check("first_grant_b", {valid_b, sel_b, grant_b}, 7'b1_00_0001);

    // Full contention: owners 0,1,2,3,0 for 8 cycles each on a; b alternates 0 and 2.
    for (int i = 0; i < 40; i++) cycle("contend", 4'b1111, 4'b0101);
    check("rotation_a", {valid_a, sel_a, grant_a}, 7'b1_01_0010);
    check("alternate_b", {valid_b, sel_b, grant_b}, 7'b1_00_0001);

    cycle("to_idle", 4'b0000, 4'b0000);
    check("idle_sel_hold_a", {valid_a, sel_a, grant_a}, 7'b0_01_0000);

    for (int i = 0; i < 20; i++) cycle("single", 4'b0100, 4'b0000);
    check("single_a", {valid_a, sel_a, grant_a}, 7'b1_10_0100);
    cycle("single_rel", 4'b0000, 4'b0000);
    check("single_rel_a", {valid_a, sel_a, grant_a}, 7'b0_10_0000);

    // Early release handover from owner 1 to 3 with no idle gap.
    cycle("own1", 4'b0010, 4'b0000);
    cycle("own1_c", 4'b1010, 4'b0000);
    cycle("own1_c", 4'b1010, 4'b0000);
    cycle("handover", 4'b1000, 4'b0000);
    check("handover_a", {valid_a, sel_a, grant_a}, 7'b1_11_1000);
    cycle("after_ho", 4'b1011, 4'b0000);
    cycle("after_ho", 4'b0011, 4'b0000);
    check("rr_wrap_a", {valid_a, sel_a, grant_a}, 7'b1_00_0001);

    // Persistent random requests, so hold limits and saturation get exercised.
    ra = 4'b0000;
    rb = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) ra = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rb = 4'($urandom_range(0, 15));
      cycle("rand", ra, rb);
    end

    // Asynchronous reset while source 3 owns the mux.
    cycle("pre_rst", 4'b0000, 4'b0000);
    cycle("pre_rst", 4'b1000, 4'b0000);
    check("pre_rst_a", {valid_a, sel_a, grant_a}, 7'b1_11_1000);
    #2;
    rst = 1'b1;
    #1;
    check("async_clear_a", {valid_a, sel_a, grant_a}, '0);
    @(posedge clk);
    #1;
    check("reset_mid_a", {valid_a, sel_a, grant_a}, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle("post_rst", 4'b1000, 4'b0000);
    check("post_rst_a", {valid_a, sel_a, grant_a}, 7'b1_11_1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
